wakeup_iqueue: RTL and testbench

- Parametrised successor to the fixed-size per-class issue queues (alu/mem/br/mul).
- One generic queue serves every class. It has WR write lanes from rename, RD issue lanes to execute and WK wakeup broadcast ports. Entries are compacted and kept in age order, and select is oldest-ready-first.
- It sits between the rename/issue register and the execute stage. An issue stage instantiates one per functional-unit class with class-specific depth and lane counts.

---
 rtl/wakeup_iqueue.sv | 168 ++++++++++++++++
 tb/tb_wakeup_iqueue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wakeup_iqueue.sv
// Generic age-ordered, compacting issue queue with wakeup broadcast.
// Select is oldest-ready-first. Survivors shift down, and new dispatches pack in behind them.
module wakeup_iqueue #(
    parameter  int unsigned QLEN   = 8,
    parameter  int unsigned WR     = 4,
    parameter  int unsigned RD     = 2,
    parameter  int unsigned WK     = 4,
    parameter  int unsigned PREG_W = 6,
    parameter  int unsigned PW     = 64,
    localparam int unsigned CW     = $clog2(QLEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 stall,
    input  logic                 wen,
    input  logic [WR-1:0]        w_valid,
    input  logic [WR*PREG_W-1:0] w_psrc1,
    input  logic [WR-1:0]        w_rdy1,
    input  logic [WR*PREG_W-1:0] w_psrc2,
    input  logic [WR-1:0]        w_rdy2,
    input  logic [WR*PW-1:0]     w_payload,
    output logic                 full,
    input  logic [WK-1:0]        wake_valid,
    input  logic [WK*PREG_W-1:0] wake_pid,
    output logic [RD-1:0]        iss_valid,
    output logic [RD*PW-1:0]     iss_payload,
    output logic [RD*PREG_W-1:0] iss_psrc1,
    output logic [RD*PREG_W-1:0] iss_psrc2,
    output logic [CW-1:0]        count
);

    logic [QLEN-1:0]   r_valid;
    logic [QLEN-1:0]   r_rdy1;
    logic [QLEN-1:0]   r_rdy2;
    logic [PREG_W-1:0] r_pid1 [QLEN];
    logic [PREG_W-1:0] r_pid2 [QLEN];
    logic [PW-1:0]     r_pay  [QLEN];
    logic [CW-1:0]     r_count;

    logic [QLEN-1:0]   w_take;
    logic              w_wr;
    logic [QLEN-1:0]   w_n_valid;
    logic [QLEN-1:0]   w_n_rdy1;
    logic [QLEN-1:0]   w_n_rdy2;
    logic [PREG_W-1:0] w_n_pid1 [QLEN];
    logic [PREG_W-1:0] w_n_pid2 [QLEN];
    logic [PW-1:0]     w_n_pay  [QLEN];
    logic [CW-1:0]     w_n_count;

    function automatic logic f_woken(input logic [PREG_W-1:0] pid,
                                     input logic [WK-1:0] wv,
                                     input logic [WK*PREG_W-1:0] wp);
        logic hit;
        hit = 1'b0;
        for (int unsigned j = 0; j < WK; j++)
            if (wv[j] && (wp[j*PREG_W +: PREG_W] == pid))
                hit = 1'b1;
        return hit;
    endfunction

    assign full  = (QLEN - 32'(r_count)) < WR;
    assign w_wr  = wen && !full && !flush;
    assign count = r_count;

    // Oldest-ready-first select: lane k takes the k-th ready slot.
    always_comb begin
        int unsigned rk;
        rk          = 0;
        w_take      = '0;
        iss_valid   = '0;
        iss_payload = '0;
        iss_psrc1   = '0;
        iss_psrc2   = '0;
        for (int unsigned i = 0; i < QLEN; i++) begin
            if (r_valid[i] && r_rdy1[i] && r_rdy2[i] && (rk < RD)) begin
                for (int unsigned k = 0; k < RD; k++) begin
                    if (k == rk) begin
                        iss_valid[k]                  = !stall;
                        iss_payload[k*PW +: PW]       = r_pay[i];
                        iss_psrc1[k*PREG_W +: PREG_W] = r_pid1[i];
                        iss_psrc2[k*PREG_W +: PREG_W] = r_pid2[i];
                    end
                end
                w_take[i] = !stall;
                rk        = rk + 1;
            end
        end
    end

    // Destination slot of each survivor and each accepted lane is a running
    // count, matched against every slot index rather than used as an index.
    always_comb begin
        int unsigned pos;
        pos       = 0;
        w_n_valid = '0;
        w_n_rdy1  = '0;
        w_n_rdy2  = '0;
        for (int unsigned d = 0; d < QLEN; d++) begin
            w_n_pid1[d] = '0;
            w_n_pid2[d] = '0;
            w_n_pay[d]  = '0;
        end
        for (int unsigned i = 0; i < QLEN; i++) begin
            if (r_valid[i] && !w_take[i]) begin
                for (int unsigned d = 0; d < QLEN; d++) begin
                    if (d == pos) begin
                        w_n_valid[d] = 1'b1;
                        w_n_rdy1[d]  = r_rdy1[i] | f_woken(r_pid1[i], wake_valid, wake_pid);
                        w_n_rdy2[d]  = r_rdy2[i] | f_woken(r_pid2[i], wake_valid, wake_pid);
                        w_n_pid1[d]  = r_pid1[i];
                        w_n_pid2[d]  = r_pid2[i];
                        w_n_pay[d]   = r_pay[i];
                    end
                end
                pos = pos + 1;
            end
        end
        if (w_wr) begin
            for (int unsigned l = 0; l < WR; l++) begin
                if (w_valid[l]) begin
                    for (int unsigned d = 0; d < QLEN; d++) begin
                        if (d == pos) begin
                            w_n_valid[d] = 1'b1;
                            w_n_rdy1[d]  = w_rdy1[l] |
                                           f_woken(w_psrc1[l*PREG_W +: PREG_W], wake_valid, wake_pid);
                            w_n_rdy2[d]  = w_rdy2[l] |
                                           f_woken(w_psrc2[l*PREG_W +: PREG_W], wake_valid, wake_pid);
                            w_n_pid1[d]  = w_psrc1[l*PREG_W +: PREG_W];
                            w_n_pid2[d]  = w_psrc2[l*PREG_W +: PREG_W];
                            w_n_pay[d]   = w_payload[l*PW +: PW];
                        end
                    end
                    pos = pos + 1;
                end
            end
        end
        w_n_count = CW'(pos);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
            r_count <= '0;
            for (int unsigned d = 0; d < QLEN; d++) begin
                r_pid1[d] <= '0;
                r_pid2[d] <= '0;
                r_pay[d]  <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_valid <= w_n_valid;
            r_rdy1  <= w_n_rdy1;
            r_rdy2  <= w_n_rdy2;
            r_count <= w_n_count;
            for (int unsigned d = 0; d < QLEN; d++) begin
                r_pid1[d] <= w_n_pid1[d];
                r_pid2[d] <= w_n_pid2[d];
                r_pay[d]  <= w_n_pay[d];
            end
        end
    end

endmodule

// File: tb/tb_wakeup_iqueue.sv
// Scoreboard bench for wakeup_iqueue: expected issues are queued at dispatch
// and popped, in order, as the issue lanes present them.
module tb_wakeup_iqueue;

    localparam int QLEN   = 8;
    localparam int WR     = 4;
    localparam int RD     = 2;
    localparam int WK     = 4;
    localparam int PREG_W = 6;
    localparam int PW     = 64;
    localparam int CW     = $clog2(QLEN + 1);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 stall;
    logic                 wen;
    logic [WR-1:0]        w_valid;
    logic [WR*PREG_W-1:0] w_psrc1;
    logic [WR-1:0]        w_rdy1;
    logic [WR*PREG_W-1:0] w_psrc2;
    logic [WR-1:0]        w_rdy2;
    logic [WR*PW-1:0]     w_payload;
    logic                 full;
    logic [WK-1:0]        wake_valid;
    logic [WK*PREG_W-1:0] wake_pid;
    logic [RD-1:0]        iss_valid;
    logic [RD*PW-1:0]     iss_payload;
    logic [RD*PREG_W-1:0] iss_psrc1;
    logic [RD*PREG_W-1:0] iss_psrc2;
    logic [CW-1:0]        count;

    typedef struct packed {
        logic [PW-1:0]     pay;
        logic [PREG_W-1:0] p1;
        logic [PREG_W-1:0] p2;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    wakeup_iqueue #(
        .QLEN(QLEN), .WR(WR), .RD(RD), .WK(WK), .PREG_W(PREG_W), .PW(PW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall), .wen(wen),
        .w_valid(w_valid), .w_psrc1(w_psrc1), .w_rdy1(w_rdy1),
        .w_psrc2(w_psrc2), .w_rdy2(w_rdy2), .w_payload(w_payload),
        .full(full), .wake_valid(wake_valid), .wake_pid(wake_pid),
        .iss_valid(iss_valid), .iss_payload(iss_payload),
        .iss_psrc1(iss_psrc1), .iss_psrc2(iss_psrc2), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        flush      = 1'b0;
        wen        = 1'b0;
        w_valid    = '0;
        w_psrc1    = '0;
        w_rdy1     = '0;
        w_psrc2    = '0;
        w_rdy2     = '0;
        w_payload  = '0;
        wake_valid = '0;
        wake_pid   = '0;
    endtask

    task automatic set_lane(input int l, input logic [PW-1:0] pay,
                            input logic [PREG_W-1:0] p1, input logic r1,
                            input logic [PREG_W-1:0] p2, input logic r2,
                            input bit push);
        exp_t e;
        wen                         = 1'b1;
        w_valid[l]                  = 1'b1;
        w_payload[l*PW +: PW]       = pay;
        w_psrc1[l*PREG_W +: PREG_W] = p1;
        w_rdy1[l]                   = r1;
        w_psrc2[l*PREG_W +: PREG_W] = p2;
        w_rdy2[l]                   = r2;
        if (push) begin
            e.pay = pay;
            e.p1  = p1;
            e.p2  = p2;
            sb.push_back(e);
        end
    endtask

    task automatic set_wake(input int j, input logic [PREG_W-1:0] pid);
        wake_valid[j]                = 1'b1;
        wake_pid[j*PREG_W +: PREG_W] = pid;
    endtask

    task automatic scan();
        exp_t e;
        for (int k = 0; k < RD; k++) begin
            if (iss_valid[k]) begin
                if (sb.size() == 0) begin
                    check("iss_spurious", 64'(iss_valid[k]), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("iss_payload", iss_payload[k*PW +: PW], e.pay);
                    check("iss_psrc", 64'({iss_psrc1[k*PREG_W +: PREG_W], iss_psrc2[k*PREG_W +: PREG_W]}),
                          64'({e.p1, e.p2}));
                end
            end
        end
    endtask

    // Inputs are driven at posedge+1, outputs scanned at posedge+4.
    task automatic cyc();
        #3;
        scan();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    initial begin
        clear_in();
        stall = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_iss", 64'(iss_valid), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_count", 64'(count), 64'd0);
        check("post_rst_full", 64'(full), 64'd0);
        check("post_rst_iss", 64'(iss_valid), 64'd0);

        // Four ready lanes drain two per cycle
        for (int l = 0; l < 4; l++) set_lane(l, 64'hA0 + 64'(l), 6'(l + 1), 1'b1, 6'd0, 1'b1, 1'b1);
        cyc();
        check("t1_count4", 64'(count), 64'd4);
        check("t1_full4", 64'(full), 64'd0);
        cyc();
        check("t1_count2", 64'(count), 64'd2);
        cyc();
        check("t1_count0", 64'(count), 64'd0);
        check("t1_drain", 64'(sb.size()), 64'd0);

        // Unready older entry is bypassed; wake makes it issue one cycle later
        set_lane(0, 64'hB0, 6'd5, 1'b0, 6'd0, 1'b1, 1'b0);
        set_lane(1, 64'hB1, 6'd7, 1'b1, 6'd0, 1'b1, 1'b1);
        cyc();
        check("t2_count2", 64'(count), 64'd2);
        sb.push_back('{pay: 64'hB0, p1: 6'd5, p2: 6'd0});
        cyc();
        check("t2_count1", 64'(count), 64'd1);
        set_wake(2, 6'd5);
        #1;
        check("t2_no_issue_on_wake", 64'(iss_valid), 64'd0);
        cyc();
        cyc();
        check("t2_woken_issued", 64'(sb.size()), 64'd0);
        check("t2_count0", 64'(count), 64'd0);

        // Wake coinciding with dispatch is captured
        set_lane(0, 64'hC0, 6'd3, 1'b1, 6'd9, 1'b0, 1'b1);
        set_wake(1, 6'd9);
        cyc();
        cyc();
        check("t3_wake_dispatch", 64'(sb.size()), 64'd0);
        check("t3_count0", 64'(count), 64'd0);

        // Full back-pressure, then recovery
        for (int l = 0; l < 4; l++) set_lane(l, 64'hD0 + 64'(l), 6'(10 + l), 1'b0, 6'd0, 1'b1, 1'b1);
        cyc();
        set_lane(0, 64'hD4, 6'd14, 1'b0, 6'd0, 1'b1, 1'b1);
        cyc();
        check("t4_count5", 64'(count), 64'd5);
        check("t4_full5", 64'(full), 64'd1);
        for (int l = 0; l < 4; l++) set_lane(l, 64'hE0 + 64'(l), 6'd1, 1'b1, 6'd1, 1'b1, 1'b0);
        cyc();
        check("t4_dropped_count", 64'(count), 64'd5);
        for (int j = 0; j < 4; j++) set_wake(j, 6'(10 + j));
        cyc();
        set_wake(0, 6'd14);
        cyc();
        check("t4_count3", 64'(count), 64'd3);
        check("t4_full3", 64'(full), 64'd0);
        stall = 1'b1;
        for (int l = 0; l < 4; l++) set_lane(l, 64'hF0 + 64'(l), 6'(20 + l), 1'b0, 6'd0, 1'b1, 1'b1);
        cyc();
        stall = 1'b0;
        check("t4_count7", 64'(count), 64'd7);
        check("t4_full7", 64'(full), 64'd1);
        for (int j = 0; j < 4; j++) set_wake(j, 6'(20 + j));
        for (int n = 0; n < 6; n++) cyc();
        check("t4_drain", 64'(sb.size()), 64'd0);
        check("t4_count0", 64'(count), 64'd0);

        // Stall holds three ready entries, then oldest two issue
        for (int l = 0; l < 3; l++) set_lane(l, 64'h1230 + 64'(l), 6'(33 + l), 1'b1, 6'(50 + l), 1'b1, 1'b1);
        cyc();
        stall = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            check("t5_stall_iss", 64'(iss_valid), 64'd0);
            cyc();
            check("t5_stall_count", 64'(count), 64'd3);
        end
        stall = 1'b0;
        cyc();
        check("t5_after_release", 64'(sb.size()), 64'd1);
        check("t5_count1", 64'(count), 64'd1);
        cyc();
        check("t5_drain", 64'(sb.size()), 64'd0);

        // Flush beats a simultaneous write and wake
        set_lane(0, 64'h70, 6'd30, 1'b0, 6'd0, 1'b1, 1'b0);
        set_lane(1, 64'h71, 6'd31, 1'b0, 6'd0, 1'b1, 1'b0);
        cyc();
        check("t6_count2", 64'(count), 64'd2);
        flush = 1'b1;
        for (int l = 0; l < 4; l++) set_lane(l, 64'h80 + 64'(l), 6'd2, 1'b1, 6'd2, 1'b1, 1'b0);
        set_wake(0, 6'd30);
        set_wake(1, 6'd31);
        cyc();
        check("t6_flush_count", 64'(count), 64'd0);
        check("t6_flush_full", 64'(full), 64'd0);
        #1;
        check("t6_flush_iss", 64'(iss_valid), 64'd0);
        cyc();
        cyc();
        check("t6_still_empty", 64'(count), 64'd0);

        // Asynchronous reset between edges
        for (int l = 0; l < 3; l++) set_lane(l, 64'h90 + 64'(l), 6'(40 + l), 1'b0, 6'd0, 1'b1, 1'b0);
        cyc();
        check("t7_count3", 64'(count), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        check("t7_arst_count", 64'(count), 64'd0);
        check("t7_arst_full", 64'(full), 64'd0);
        check("t7_arst_iss", 64'(iss_valid), 64'd0);
        #1;
        reset = 1'b0;
        for (int j = 0; j < 3; j++) set_wake(j, 6'(40 + j));
        cyc();
        cyc();
        check("t7_post_count", 64'(count), 64'd0);
        set_lane(0, 64'h5A5A, 6'd12, 1'b1, 6'd13, 1'b1, 1'b1);
        cyc();
        cyc();
        check("t7_reuse", 64'(sb.size()), 64'd0);
        check("t7_final_count", 64'(count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
